// File: rtl/cpu_pkg.sv
// Shared core types and constants: widths, reset PC, the halt encoding and the
// {pc, instr} record carried from fetch to decode.
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0]    RESET_PC   = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect input and the decode handshake.
interface fetch_unit_if #(
    parameter int XLEN = 32
) ();

    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            halted;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  halted
    );

endinterface

// File: rtl/fetch_queue.sv
// In-order FIFO of fetch entries; flush wins over push/pop, head reads as zero when empty.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop) & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Front-end fetch: PC register, halt detection and redirect handling feeding an
// in-order {pc, instr} queue that decode drains through valid/ready.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int              IQ_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_next;
    logic             pop;
    logic             can_push;
    logic             is_halt;
    logic             push;
    logic             q_full;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;
    fetch_entry_t     q_din;
    fetch_entry_t     q_head;

    assign pop      = ~q_empty & bus.out_ready;
    assign is_halt  = (bus.imem_rdata == HALT_INSTR);
    assign can_push = (state == FETCH) & ~bus.redirect_valid & (~q_full | pop);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Redirect outranks everything, including leaving HALT and any pending push.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        if (bus.redirect_valid) begin
            state_next = FETCH;
            pc_next    = {bus.redirect_pc[XLEN-1:2], 2'b00};
        end else if (can_push) begin
            if (is_halt) begin
                state_next = HALT;
            end else begin
                push    = 1'b1;
                pc_next = pc + XLEN'(4);
            end
        end
    end

    always_comb begin
        q_din       = '0;
        q_din.pc    = pc;
        q_din.instr = bus.imem_rdata;
    end

    fetch_queue #(
        .DEPTH (IQ_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rstn),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (q_din),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count),
        .head  (q_head)
    );

    assign bus.imem_addr = pc;
    assign bus.out_valid = ~q_empty;
    assign bus.out_pc    = q_head.pc;
    assign bus.out_instr = q_head.instr;
    assign bus.halted    = (state == HALT);

    a_count_bound: assert property (@(posedge clk) disable iff (rstn)
        q_count <= CNT_W'(IQ_DEPTH));

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end fetch stage of the out-of-order RISC-V core. It sits directly downstream of the top-level clock/reset and upstream of decode/rename, and is the first block that reacts when reset is released. It holds the PC, reads one 32-bit instruction per cycle from instruction memory, and buffers {pc, instr} pairs in a small in-order queue. Decode drains the queue through a valid/ready handshake. A redirect from branch resolution flushes the queue and restarts fetch.

## Interface
Parameters:
- XLEN, 32, PC/data width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- IQ_DEPTH, 4, fetch-queue entries (power of two, ≥2)

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rstn  in  1  asynchronous, active-high reset: asserting 1 immediately clears all state
- imem_addr  out  XLEN  byte address of the instruction being fetched; equals the PC register
- imem_rdata  in  32  instruction at imem_addr; combinational, same cycle
- redirect_valid  in  1  flush request from branch/jump resolution
- redirect_pc  in  XLEN  new fetch target; low 2 bits ignored (forced to 0)
- out_valid  out  1  queue head is valid
- out_ready  in  1  decode accepts the head this cycle
- out_pc  out  XLEN  PC of the head entry
- out_instr  out  32  instruction of the head entry
- halted  out  1  fetch has stopped on the halt encoding

## Operation
- pop = out_valid & out_ready.
- can_push = !halted & !redirect_valid & (count < IQ_DEPTH | pop).
- Fetch when can_push:
  - imem_rdata != 32'h0000_0000: push {pc, imem_rdata} at the tail and set pc ← pc + 4. Wraps modulo 2^XLEN.
  - imem_rdata == 32'h0000_0000 (halt encoding): no push; halted ← 1; pc holds.
- Queue is strictly in order. Push and pop in the same cycle are allowed when full or empty. On empty, the pushed entry becomes visible next cycle; there is no bypass.
- Redirect has highest priority. In that cycle: queue count and pointers → 0; pc ← {redirect_pc[XLEN-1:2], 2'b00}; halted ← 0; no push. A pop in the same cycle is discarded and counts as flushed.
- When the queue is empty: out_valid = 0, and out_pc and out_instr drive 0.
- States: FETCH (halted=0) and HALT (halted=1).
  - FETCH → HALT on the halt encoding.
  - HALT → FETCH only on redirect or reset.
  - In HALT, the queue continues to drain normally.

## Timing
- Reset values: pc = RESET_PC, imem_addr = RESET_PC, count = 0, out_valid = 0, out_pc = 0, out_instr = 0, halted = 0.
- Reset asserted mid-operation clears everything asynchronously, including in-flight queue contents.
- Fetch-to-output latency is 1 cycle. An instruction sampled at edge N appears on out_* after edge N and can be consumed at edge N+1.
- Throughput is 1 instruction/cycle in steady state with out_ready held high.
- Redirect at edge N: out_valid = 0 after N. The first instruction from redirect_pc is fetched at edge N+1 and is valid after N+1.
- With the queue full and out_ready = 0: pc and imem_addr hold, and the queue contents are stable.

## Structure
- Shared package cpu_pkg:
  - XLEN, RESET_PC, INSTR_W = 32
  - HALT_INSTR = 32'h0
  - fetch-entry typedef {pc, instr}
- Sub-module fetch_queue: synchronous FIFO of fetch entries with push, pop, flush, full, empty, count, and head outputs.
- fetch_unit instantiates fetch_queue and contains the PC register, the halted flag, and the push/redirect control.

## Test plan
- Reset, then reset release with imem holding 4 non-zero words at 0x0–0xC and out_ready=1 → out_pc = 0x0, 0x4, 0x8, 0xC on consecutive cycles; imem_addr increments by 4 each cycle.
- out_ready=0 for 8 cycles → count saturates at 4 and imem_addr holds at 0x10. Then out_ready=1 → entries 0x0–0xC drain in order, followed by 0x10 with no gap or duplicate.
- Word 0x10 = 0 → halted rises after the edge that samples it, 0x10 is never output, and the queue drains to out_valid=0. Then redirect_pc=0x0 → halted=0 and fetch resumes at 0x0.
- redirect_valid with redirect_pc=0x42 while the queue holds 3 entries and out_ready=1 → no entry is output that cycle, out_valid=0 next cycle, then out_pc = 0x40.
- Reset asserted for 1 ns in mid-stream → all outputs return to their reset values asynchronously (out_valid = 0, out_pc = 0, out_instr = 0, halted = 0, imem_addr = RESET_PC) before the next clock edge, and fetch restarts at RESET_PC.
- pc = 0xFFFF_FFFC with a non-zero word → entry pushed, pc wraps to 0x0000_0000.
